// File: rtl/demux_1_8_seq.sv
// Registered 1-to-8 demultiplexer with valid/ready input, per-channel hold-until-ack
// registers, and an optional round-robin channel pointer.
module demux_1_8_seq #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] d,
  input  logic [2:0]       s,
  input  logic             auto_mode,
  input  logic             clear,
  input  logic [7:0]       rd_ack,
  output logic [WIDTH-1:0] y0,
  output logic [WIDTH-1:0] y1,
  output logic [WIDTH-1:0] y2,
  output logic [WIDTH-1:0] y3,
  output logic [WIDTH-1:0] y4,
  output logic [WIDTH-1:0] y5,
  output logic [WIDTH-1:0] y6,
  output logic [WIDTH-1:0] y7,
  output logic [7:0]       y_valid,
  output logic [2:0]       cnt,
  output logic             frame_done
);

  logic [WIDTH-1:0] y_p0 [8];
  logic [2:0]       sel;
  logic             acc;
  logic [7:0]       wr_mask;

  function automatic logic [2:0] cnt_next(input logic [2:0] c);
    return 3'(c + 3'd1);
  endfunction

  // Select and handshake: in_ready never depends on in_valid.
  always_comb begin
    sel      = auto_mode ? cnt : s;
    in_ready = ~clear & (~y_valid[sel] | rd_ack[sel]);
    acc      = in_valid & in_ready;
    wr_mask  = acc ? (8'b1 << sel) : 8'b0;
  end

  // Stage p0: channel registers, flags and pointer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < 8; k++) y_p0[k] <= '0;
      y_valid    <= '0;
      cnt        <= '0;
      frame_done <= 1'b0;
    end else if (clear) begin
      y_valid    <= '0;
      cnt        <= '0;
      frame_done <= 1'b0;
    end else begin
      // A write wins over an ack on the same channel: the ack consumes the old word.
      y_valid    <= (y_valid & ~rd_ack) | wr_mask;
      if (acc) y_p0[sel] <= d;
      if (acc && auto_mode) cnt <= cnt_next(cnt);
      frame_done <= acc & auto_mode & (cnt == 3'd7);
    end
  end

  assign y0 = y_p0[0];
  assign y1 = y_p0[1];
  assign y2 = y_p0[2];
  assign y3 = y_p0[3];
  assign y4 = y_p0[4];
  assign y5 = y_p0[5];
  assign y6 = y_p0[6];
  assign y7 = y_p0[7];

endmodule

// File: tb/tb_demux_1_8_seq.sv
// Bench for demux_1_8_seq: behavioural reference model plus a scoreboard of
// accepted words, with directed checks for each operating scenario.
module tb_demux_1_8_seq;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n, in_valid, in_ready, auto_mode, clear, frame_done;
  logic [W-1:0] d, y0, y1, y2, y3, y4, y5, y6, y7;
  logic [2:0]   s, cnt;
  logic [7:0]   rd_ack, y_valid;

  demux_1_8_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .d(d), .s(s),
    .auto_mode(auto_mode), .clear(clear), .rd_ack(rd_ack),
    .y0(y0), .y1(y1), .y2(y2), .y3(y3), .y4(y4), .y5(y5), .y6(y6), .y7(y7),
    .y_valid(y_valid), .cnt(cnt), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct { logic [2:0] ch; logic [W-1:0] dat; } sb_t;
  sb_t sb_q[$];

  logic [W-1:0] m_y [8];
  logic [7:0]   m_v;
  logic [2:0]   m_cnt;
  logic         m_fd;
  int           n_chk = 0;
  int           n_err = 0;
  int           fd_seen;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [W-1:0] ydut(input int k);
    case (k)
      0: return y0; 1: return y1; 2: return y2; 3: return y3;
      4: return y4; 5: return y5; 6: return y6; default: return y7;
    endcase
  endfunction

  task automatic drive(input logic rn, input logic iv, input logic [2:0] ss,
                       input logic [W-1:0] dd, input logic am, input logic cl,
                       input logic [7:0] ack);
    rst_n = rn; in_valid = iv; s = ss; d = dd; auto_mode = am; clear = cl; rd_ack = ack;
    #1;
  endtask

  // One clock: check in_ready against the model, advance model, check outputs.
  task automatic tick();
    logic [2:0] msel;
    logic       mrdy, macc;
    sb_t        e;
    msel = auto_mode ? m_cnt : s;
    mrdy = !clear && (!m_v[msel] || rd_ack[msel]);
    macc = rst_n && in_valid && mrdy;
    if (rst_n) chk("in_ready", 32'(in_ready), 32'(mrdy));
    if (macc) begin
      e.ch = msel; e.dat = d;
      sb_q.push_back(e);
    end
    @(posedge clk);
    if (!rst_n) begin
      for (int k = 0; k < 8; k++) m_y[k] = '0;
      m_v = '0; m_cnt = '0; m_fd = 1'b0;
    end else if (clear) begin
      m_v = '0; m_cnt = '0; m_fd = 1'b0;
    end else begin
      for (int k = 0; k < 8; k++) begin
        if (macc && k == int'(msel)) begin
          m_y[k] = d; m_v[k] = 1'b1;
        end else if (rd_ack[k]) m_v[k] = 1'b0;
      end
      m_fd = macc && auto_mode && (m_cnt == 3'd7);
      if (macc && auto_mode) m_cnt = m_cnt + 3'd1;
    end
    #1;
    chk("y_valid", 32'(y_valid), 32'(m_v));
    chk("cnt", 32'(cnt), 32'(m_cnt));
    chk("frame_done", 32'(frame_done), 32'(m_fd));
    if (frame_done === 1'b1) fd_seen++;
    for (int k = 0; k < 8; k++) chk($sformatf("y%0d", k), 32'(ydut(k)), 32'(m_y[k]));
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      if (rst_n) begin
        chk("sb_data", 32'(ydut(int'(e.ch))), 32'(e.dat));
        chk("sb_valid", 32'(y_valid[e.ch]), 32'd1);
      end
    end
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 3'd0, '0, 1'b0, 1'b0, 8'h00); tick();
    drive(1'b0, 1'b0, 3'd0, '0, 1'b0, 1'b0, 8'h00); tick();
  endtask

  initial begin
    for (int k = 0; k < 8; k++) m_y[k] = '0;
    m_v = '0; m_cnt = '0; m_fd = 1'b0; fd_seen = 0;

    // Reset then explicit mode
    do_reset();
    drive(1'b1, 1'b0, 3'd0, '0, 1'b0, 1'b0, 8'h00);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_y_valid", 32'(y_valid), 32'h0);
    chk("rst_cnt", 32'(cnt), 32'd0);
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 1'b1, 3'(k), W'(k), 1'b0, 1'b0, 8'h00); tick();
    end
    chk("expl_y_valid", 32'(y_valid), 32'hFF);
    chk("expl_cnt", 32'(cnt), 32'd0);
    chk("expl_fd_count", 32'(fd_seen), 32'd0);
    for (int k = 0; k < 8; k++) chk($sformatf("expl_y%0d", k), 32'(ydut(k)), 32'(k));
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 1'b1, 3'(k), '0, 1'b0, 1'b0, 8'h00);
      chk("expl_full_ready", 32'(in_ready), 32'd0);
    end
    drive(1'b1, 1'b0, 3'd0, '0, 1'b0, 1'b0, 8'h00); tick();

    // Auto mode round-robin with continuous acks
    do_reset();
    fd_seen = 0;
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, 1'b1, 3'd0, W'(k), 1'b1, 1'b0, 8'hFF);
      chk("rr_no_stall", 32'(in_ready), 32'd1);
      chk("rr_cnt_pre", 32'(cnt), 32'(k % 8));
      tick();
      if (k == 7) chk("rr_wrap_fd", 32'(frame_done), 32'd1);
      if (k == 0) chk("rr_y0_first", 32'(y0), 32'd0);
    end
    chk("rr_fd_once", 32'(fd_seen), 32'd1);
    chk("rr_y0", 32'(y0), 32'd8);
    chk("rr_y1", 32'(y1), 32'd9);
    chk("rr_cnt_end", 32'(cnt), 32'd2);

    // Stall and release on channel 3
    do_reset();
    drive(1'b1, 1'b1, 3'd3, W'(4'b0101), 1'b0, 1'b0, 8'h00); tick();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b1, 3'd3, W'(4'b0010), 1'b0, 1'b0, 8'h00);
      chk("stall_ready", 32'(in_ready), 32'd0);
      tick();
      chk("stall_y3", 32'(y3), 32'b0101);
    end
    drive(1'b1, 1'b1, 3'd3, W'(4'b0010), 1'b0, 1'b0, 8'h08);
    chk("release_ready", 32'(in_ready), 32'd1);
    tick();
    chk("release_y3", 32'(y3), 32'b0010);
    chk("release_v3", 32'(y_valid[3]), 32'd1);

    // Ack on empty channel, then write and ack-only
    drive(1'b1, 1'b0, 3'd0, '0, 1'b0, 1'b0, 8'h20); tick();
    chk("empty_ack_v", 32'(y_valid), 32'h08);
    drive(1'b1, 1'b1, 3'd5, W'(6), 1'b0, 1'b0, 8'h00); tick();
    chk("wr5_v", 32'(y_valid[5]), 32'd1);
    drive(1'b1, 1'b0, 3'd5, '0, 1'b0, 1'b0, 8'h20); tick();
    chk("ack5_v", 32'(y_valid[5]), 32'd0);
    chk("ack5_y", 32'(y5), 32'd6);

    // Clear mid-frame
    do_reset();
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 1'b1, 3'd0, W'(k + 1), 1'b1, 1'b0, 8'h00); tick();
    end
    chk("clr_cnt_pre", 32'(cnt), 32'd5);
    drive(1'b1, 1'b1, 3'd0, W'(9), 1'b1, 1'b1, 8'h00);
    chk("clr_ready", 32'(in_ready), 32'd0);
    tick();
    chk("clr_v", 32'(y_valid), 32'h0);
    chk("clr_cnt", 32'(cnt), 32'd0);
    chk("clr_fd", 32'(frame_done), 32'd0);
    for (int k = 0; k < 5; k++) chk($sformatf("clr_y%0d", k), 32'(ydut(k)), 32'(k + 1));
    chk("clr_y5", 32'(y5), 32'd0);

    // Reset mid-operation at cnt = 6
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, 1'b1, 3'd0, W'(10 + k), 1'b1, 1'b0, 8'hFF); tick();
    end
    chk("mid_cnt_pre", 32'(cnt), 32'd6);
    drive(1'b0, 1'b1, 3'd0, W'(15), 1'b1, 1'b0, 8'h00); tick();
    drive(1'b1, 1'b0, 3'd0, '0, 1'b1, 1'b0, 8'h00);
    chk("mid_rst_v", 32'(y_valid), 32'h0);
    chk("mid_rst_cnt", 32'(cnt), 32'd0);
    chk("mid_rst_fd", 32'(frame_done), 32'd0);
    chk("mid_rst_ready", 32'(in_ready), 32'd1);
    for (int k = 0; k < 8; k++) chk($sformatf("mid_rst_y%0d", k), 32'(ydut(k)), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/demux_1_8_seq.md
# demux_1_8_seq

Registered 1-to-8 demultiplexer: the receiving-side counterpart of the 8:1 selector family. It accepts a stream of WIDTH-bit words with a valid/ready handshake and routes each word to one of eight holding registers. The target channel comes from an explicit select or from an internal round-robin counter. Each channel holds its word until the downstream consumer acknowledges it, so the block can sit between a serialized bus and eight parallel consumers.

## Interface
- WIDTH, 3, data width of each word and of every channel register

- clk  input  1  clock; all state changes on rising edge
- rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
- in_valid  input  1  upstream presents a word on d
- in_ready  output  1  block can accept the word this cycle
- d  input  WIDTH  data word
- s  input  3  explicit channel select, used when auto_mode = 0
- auto_mode  input  1  1 = use internal counter as select, 0 = use s
- clear  input  1  synchronous: drop all channel flags and zero counter
- rd_ack  input  8  per-channel acknowledge from consumer; bit k clears channel k
- y0..y7  output  WIDTH each  channel holding registers
- y_valid  output  8  bit k = channel k holds unacknowledged data
- cnt  output  3  current round-robin pointer
- frame_done  output  1  one-cycle pulse when the counter wraps 7 -> 0

## Operation
- Effective select: sel = auto_mode ? cnt : s. This is evaluated combinationally each cycle.
- in_ready = ~clear & (~y_valid[sel] | rd_ack[sel]). This is combinational. A channel that is full and not being acked stalls the input.
- Accept: acc = in_valid & in_ready. On acc, y[sel] <= d and y_valid[sel] <= 1.
- Ack: for each k with rd_ack[k] = 1 and no write to k this cycle, y_valid[k] <= 0. y[k] keeps its value; data is never zeroed by ack.
- Simultaneous write and ack on the same channel: the new word is loaded and y_valid stays 1. The ack consumes the old word.
- rd_ack on a channel that is already empty: no effect.
- Counter: cnt advances by 1 (mod 8) only on acc with auto_mode = 1.
  - On an acc at cnt = 7, cnt wraps to 0 and frame_done = 1 for the next cycle only.
  - With auto_mode = 0, cnt holds its value. Switching modes never modifies cnt.
- clear (priority over everything except rst_n):
  - y_valid <= 0, cnt <= 0, frame_done <= 0.
  - in_ready is held 0, so no accept happens that cycle.
  - y0..y7 keep their data.
- Reset (rst_n = 0 at an edge): y0..y7 = 0, y_valid = 0, cnt = 0, frame_done = 0. in_ready then evaluates to 1 (all channels empty, clear = 0). Reset mid-transfer discards all state, and an in_valid in the reset cycle is ignored.
- Words are never dropped or duplicated. Every accepted word lands in exactly one channel.

## Timing
- Write latency: a word accepted at edge N is visible on y[sel] and y_valid[sel] after edge N; zero bubbles.
- Throughput: 1 word/cycle while the target channel is empty or being acked in the same cycle.
- in_ready, sel: combinational from y_valid, cnt, s, auto_mode, rd_ack, clear. There is no combinational path from in_valid to in_ready.
- frame_done: registered, high exactly 1 cycle after the wrapping accept.
- rd_ack effect is visible on y_valid one cycle later.
- All outputs except in_ready are registered.

## Test plan
- Reset then explicit mode:
  - Stimulus: rst_n low 2 cycles; then auto_mode = 0, send d = s = 0..7 with in_valid = 1 and no acks.
  - Required: y_k = k for all k; y_valid = 8'hFF; in_ready = 0 afterwards for any s; cnt stays 0; no frame_done.
- Auto mode round-robin:
  - Stimulus: after reset, auto_mode = 1, rd_ack = 8'hFF continuously, stream d = 0,1,2,...,9.
  - Required: cnt sequence 0..7,0,1,2. y0 = 0 then 8, y1 = 1 then 9. frame_done high exactly once, the cycle after the word 7 accept. No stall cycles.
- Stall and release:
  - Stimulus: fill channel 3 with 3'b101, then present s = 3, d = 3'b010 with no ack for 3 cycles, then rd_ack[3] = 1 for 1 cycle.
  - Required: in_ready = 0 for 3 cycles; y3 stays 101. Accept occurs in the ack cycle, then y3 = 010 and y_valid[3] = 1.
- Ack on empty channel and ack-only:
  - Stimulus: pulse rd_ack[5] with y_valid[5] = 0; then write channel 5 and ack it with no new write.
  - Required: first pulse does nothing; after the ack, y_valid[5] = 0 and y5 retains its data.
- Clear mid-frame:
  - Stimulus: auto_mode = 1, accept 5 words (cnt = 5), then assert clear for 1 cycle while in_valid = 1.
  - Required: in_ready = 0 during clear; next cycle y_valid = 0 and cnt = 0; data registers unchanged; no frame_done.
- Reset mid-operation:
  - Stimulus: assert rst_n = 0 while in_valid = 1 and cnt = 6.
  - Required: after the edge, all outputs are zero and in_ready = 1; the word presented during reset is not stored.
